// File: rtl/fmul_round_pack.sv
// Back end of a single-precision multiplier. It normalizes the raw 48-bit product and
// rounds it to nearest-even, then packs the IEEE-754 word over two pipeline stages with backpressure.
module fmul_round_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exp,
    input  logic [47:0] in_mant,
    input  logic        in_nan,
    input  logic        in_inf,
    input  logic        in_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_flags,
    output logic [3:0]  sticky_flags,
    input  logic        flags_clr,
    output logic [15:0] op_count
);

    localparam logic [1:0] CLS_NORM = 2'd0;
    localparam logic [1:0] CLS_ZERO = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_NAN  = 2'd3;

    logic               s1_valid_q;
    logic               s1_sign_q,  s1_sign_d;
    logic signed [10:0] s1_exp_q,   s1_exp_d;
    logic [22:0]        s1_frac_q,  s1_frac_d;
    logic               s1_g_q,     s1_g_d;
    logic               s1_s_q,     s1_s_d;
    logic [1:0]         s1_cls_q,   s1_cls_d;

    logic               s2_valid_q;
    logic [31:0]        s2_result_q, s2_result_d;
    logic [3:0]         s2_flags_q,  s2_flags_d;
    logic [3:0]         sticky_q,    sticky_d;
    logic [15:0]        count_q,     count_d;

    logic               s2_adv, s1_adv, out_acc;
    logic               round_up, inexact;
    logic [23:0]        frac_rnd;
    logic signed [10:0] exp_rnd;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv && rst_n;
    assign out_acc  = s2_valid_q && out_ready;

    // S1: normalize to 1.f with guard and sticky; exponent widened so overflow stays visible
    always_comb begin
        s1_sign_d = in_sign;
        if (in_mant[47]) begin
            s1_frac_d = in_mant[46:24];
            s1_g_d    = in_mant[23];
            s1_s_d    = |in_mant[22:0];
            s1_exp_d  = {in_exp[9], in_exp} + 11'sd1;
        end else begin
            s1_frac_d = in_mant[45:23];
            s1_g_d    = in_mant[22];
            s1_s_d    = |in_mant[21:0];
            s1_exp_d  = {in_exp[9], in_exp};
        end
        if (in_nan)       s1_cls_d = CLS_NAN;
        else if (in_inf)  s1_cls_d = CLS_INF;
        else if (in_zero) s1_cls_d = CLS_ZERO;
        else              s1_cls_d = CLS_NORM;
    end

    // S2: round to nearest even; a carry out of the fraction bumps the exponent
    always_comb begin
        round_up = s1_g_q && (s1_s_q || s1_frac_q[0]);
        inexact  = s1_g_q || s1_s_q;
        frac_rnd = {1'b0, s1_frac_q} + {23'd0, round_up};
        exp_rnd  = s1_exp_q + {10'd0, frac_rnd[23]};
        case (s1_cls_q)
            CLS_NAN: begin
                s2_result_d = 32'h7FC0_0000;
                s2_flags_d  = 4'b1000;
            end
            CLS_INF: begin
                s2_result_d = {s1_sign_q, 8'hFF, 23'd0};
                s2_flags_d  = 4'b0000;
            end
            CLS_ZERO: begin
                s2_result_d = {s1_sign_q, 31'd0};
                s2_flags_d  = 4'b0000;
            end
            default: begin
                if (exp_rnd >= 11'sd255) begin
                    s2_result_d = {s1_sign_q, 8'hFF, 23'd0};
                    s2_flags_d  = 4'b0101;
                end else if (exp_rnd <= 11'sd0) begin
                    s2_result_d = {s1_sign_q, 31'd0};
                    s2_flags_d  = 4'b0011;
                end else begin
                    s2_result_d = {s1_sign_q, exp_rnd[7:0], frac_rnd[22:0]};
                    s2_flags_d  = {3'b000, inexact};
                end
            end
        endcase
    end

    always_comb begin
        if (out_acc)        sticky_d = (flags_clr ? 4'd0 : sticky_q) | s2_flags_q;
        else if (flags_clr) sticky_d = 4'd0;
        else                sticky_d = sticky_q;
        count_d = count_q + {15'd0, out_acc};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= 11'sd0;
            s1_frac_q   <= 23'd0;
            s1_g_q      <= 1'b0;
            s1_s_q      <= 1'b0;
            s1_cls_q    <= CLS_NORM;
            s2_valid_q  <= 1'b0;
            s2_result_q <= 32'd0;
            s2_flags_q  <= 4'd0;
            sticky_q    <= 4'd0;
            count_q     <= 16'd0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_sign_q <= s1_sign_d;
                    s1_exp_q  <= s1_exp_d;
                    s1_frac_q <= s1_frac_d;
                    s1_g_q    <= s1_g_d;
                    s1_s_q    <= s1_s_d;
                    s1_cls_q  <= s1_cls_d;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_result_q <= s2_result_d;
                    s2_flags_q  <= s2_flags_d;
                end
            end
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_result   = s2_result_q;
    assign out_flags    = s2_flags_q;
    assign sticky_flags = sticky_q;
    assign op_count     = count_q;

endmodule

// File: tb/tb_fmul_round_pack.sv
// Directed bench for fmul_round_pack: rounding, specials, flags, backpressure and reset.
module tb_fmul_round_pack;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_sign, in_nan, in_inf, in_zero;
    logic [9:0]  in_exp;
    logic [47:0] in_mant;
    logic        out_valid, out_ready, flags_clr;
    logic [31:0] out_result;
    logic [3:0]  out_flags, sticky_flags;
    logic [15:0] op_count;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;
    logic [3:0] exp_sticky = 4'd0;

    fmul_round_pack dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .sticky_flags(sticky_flags), .flags_clr(flags_clr),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic s, input logic [9:0] e, input logic [47:0] m, input logic [2:0] cls);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        {in_nan, in_inf, in_zero} = cls;
    endtask

    // one transaction with out_ready=1; output is accepted on the edge after the lat2 sample
    task automatic send(input string tag, input logic s, input logic [9:0] e, input logic [47:0] m,
                        input logic [2:0] cls, input logic clr,
                        input logic [31:0] er, input logic [3:0] ef);
        @(negedge clk);
        flags_clr = 1'b0;
        drive(s, e, m, cls);
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, " lat1 out_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({tag, " lat2 out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " result"}, out_result, er);
        check({tag, " flags"}, 32'(out_flags), 32'(ef));
        flags_clr  = clr;
        exp_sticky = (clr ? 4'd0 : exp_sticky) | ef;
        exp_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flags_clr = 1'b0;
        in_sign = 1'b0; in_exp = 10'd0; in_mant = 48'd0;
        in_nan = 1'b0; in_inf = 1'b0; in_zero = 1'b0;
        repeat (3) @(negedge clk);
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_result", out_result, 32'd0);
        check("rst out_flags", 32'(out_flags), 32'd0);
        check("rst sticky", 32'(sticky_flags), 32'd0);
        check("rst op_count", 32'(op_count), 32'd0);
        rst_n = 1'b1;

        send("1.5x2",      1'b0, 10'd128, 48'h6000_0000_0000, 3'b000, 1'b0, 32'h4040_0000, 4'b0000);
        send("1.5x1.5",    1'b0, 10'd127, 48'h9000_0000_0000, 3'b000, 1'b0, 32'h4010_0000, 4'b0000);
        send("rne_tie_ev", 1'b0, 10'd127, 48'h4000_0040_0000, 3'b000, 1'b0, 32'h3F80_0000, 4'b0001);
        send("rne_tie_up", 1'b0, 10'd127, 48'h4000_00C0_0000, 3'b000, 1'b0, 32'h3F80_0002, 4'b0001);
        send("rne_carry",  1'b0, 10'd127, 48'h7FFF_FFC0_0000, 3'b000, 1'b0, 32'h4000_0000, 4'b0001);
        send("neg_one",    1'b1, 10'd127, 48'h4000_0000_0000, 3'b000, 1'b0, 32'hBF80_0000, 4'b0000);
        send("overflow",   1'b0, 10'd254, 48'h8000_0000_0000, 3'b000, 1'b0, 32'h7F80_0000, 4'b0101);
        send("underflow",  1'b0, 10'h3FB, 48'h4000_0000_0000, 3'b000, 1'b0, 32'h0000_0000, 4'b0011);
        send("exp0_flush", 1'b1, 10'd0,   48'h4000_0000_0000, 3'b000, 1'b0, 32'h8000_0000, 4'b0011);
        send("exp1_min",   1'b0, 10'd1,   48'h4000_0000_0000, 3'b000, 1'b0, 32'h0080_0000, 4'b0000);
        send("exp254_max", 1'b0, 10'd254, 48'h4000_0000_0000, 3'b000, 1'b0, 32'h7F00_0000, 4'b0000);
        send("inf",        1'b1, 10'd5,   48'h1234_5678_9ABC, 3'b010, 1'b0, 32'hFF80_0000, 4'b0000);
        send("zero",       1'b1, 10'd300, 48'hFFFF_FFFF_FFFF, 3'b001, 1'b0, 32'h8000_0000, 4'b0000);
        @(negedge clk);
        check("sticky accum", 32'(sticky_flags), 32'(exp_sticky));
        send("nan_prio",   1'b1, 10'd127, 48'h4000_0000_0000, 3'b111, 1'b1, 32'h7FC0_0000, 4'b1000);
        @(negedge clk);
        flags_clr = 1'b0;
        check("sticky clr+acc", 32'(sticky_flags), 32'(exp_sticky));
        check("op_count seq", 32'(op_count), 32'(exp_cnt));

        // backpressure after a fresh reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        drive(1'b0, 10'd127, 48'h4000_0000_0000, 3'b000);
        check("bp A in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        drive(1'b0, 10'd128, 48'h4000_0000_0000, 3'b000);
        check("bp B in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        drive(1'b0, 10'd129, 48'h4000_0000_0000, 3'b000);
        check("bp C stalled", 32'(in_ready), 32'd0);
        check("bp A valid", 32'(out_valid), 32'd1);
        check("bp A result", out_result, 32'h3F80_0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp hold in_ready", 32'(in_ready), 32'd0);
            check("bp hold result", out_result, 32'h3F80_0000);
            check("bp hold valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp B valid", 32'(out_valid), 32'd1);
        check("bp B result", out_result, 32'h4000_0000);
        @(negedge clk);
        check("bp C valid", 32'(out_valid), 32'd1);
        check("bp C result", out_result, 32'h4080_0000);
        @(negedge clk);
        check("bp drained", 32'(out_valid), 32'd0);
        check("bp op_count", 32'(op_count), 32'd3);

        // reset with both stages full
        out_ready = 1'b0;
        drive(1'b0, 10'd254, 48'h8000_0000_0000, 3'b000);
        @(negedge clk);
        drive(1'b1, 10'd127, 48'h4000_0000_0000, 3'b000);
        @(negedge clk);
        in_valid = 1'b0;
        check("mid full valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid rst in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("mid rst out_valid", 32'(out_valid), 32'd0);
        check("mid rst result", out_result, 32'd0);
        check("mid rst flags", 32'(out_flags), 32'd0);
        check("mid rst sticky", 32'(sticky_flags), 32'd0);
        check("mid rst op_count", 32'(op_count), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post rst no out", 32'(out_valid), 32'd0);
        end
        check("post rst op_count", 32'(op_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
